// File: rtl/if_prefetch_stage.sv
// Instruction-fetch stage: issues sequential word fetches over req/gnt/rvalid and
// buffers returned words with their PC in a small FIFO that feeds ID over valid/ready.
module if_prefetch_stage #(
   parameter int unsigned FIFO_DEPTH = 2,
   parameter int unsigned INC_WIDTH  = 3
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        fetch_en_i,
   input  logic [31:0] boot_addr_i,
   input  logic        redirect_i,
   input  logic [31:0] redirect_addr_i,
   output logic        instr_req_o,
   output logic [31:0] instr_addr_o,
   input  logic        instr_gnt_i,
   input  logic        instr_rvalid_i,
   input  logic [31:0] instr_rdata_i,
   output logic        instr_valid_o,
   input  logic        instr_ready_i,
   output logic [31:0] instr_rdata_o,
   output logic [31:0] instr_pc_o,
   output logic        busy_o
);

   localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned SUM_W = INC_WIDTH + 2;

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      FETCH = 1'b1
   } state_e;

   state_e               state_q, state_d;
   logic [31:0]          fetch_addr_q, fetch_addr_d;
   logic [31:0]          resp_pc_q, resp_pc_d;
   logic [INC_WIDTH-1:0] outstanding_q, outstanding_d;
   logic [INC_WIDTH-1:0] discard_q, discard_d;
   logic                 req_hold_q, req_hold_d;
   logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]     count_q, count_d;
   logic [31:0]          pc_mem_q [FIFO_DEPTH];
   logic [31:0]          pc_mem_d [FIFO_DEPTH];
   logic [31:0]          data_mem_q [FIFO_DEPTH];
   logic [31:0]          data_mem_d [FIFO_DEPTH];

   logic [SUM_W-1:0]     inflight_s;
   logic                 credit_s;
   logic                 req_s;
   logic                 req_gnt_s;
   logic                 push_s;
   logic                 pop_s;
   logic [31:0]          redirect_tgt_s;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
      logic [PTR_W-1:0] nxt;
      if (ptr == PTR_W'(FIFO_DEPTH - 1)) begin
         nxt = '0;
      end else begin
         nxt = ptr + PTR_W'(1);
      end
      return nxt;
   endfunction

   // Credit counts buffered words plus every response still owed by memory, stale or not.
   assign inflight_s     = SUM_W'(count_q) + SUM_W'(outstanding_q) + SUM_W'(discard_q);
   assign credit_s       = (inflight_s < SUM_W'(FIFO_DEPTH));
   assign req_s          = (state_q == FETCH) & ~redirect_i & (req_hold_q | (fetch_en_i & credit_s));
   assign req_gnt_s      = req_s & instr_gnt_i;
   assign redirect_tgt_s = redirect_addr_i & 32'hFFFF_FFFC;

   assign instr_req_o   = req_s;
   assign instr_addr_o  = fetch_addr_q;
   assign instr_valid_o = (count_q != '0);
   assign instr_rdata_o = data_mem_q[rd_ptr_q];
   assign instr_pc_o    = pc_mem_q[rd_ptr_q];
   assign busy_o        = (outstanding_q != '0) | (count_q != '0);

   // Next-state, counter and FIFO update logic
   always_comb begin
      state_d       = state_q;
      fetch_addr_d  = fetch_addr_q;
      resp_pc_d     = resp_pc_q;
      outstanding_d = outstanding_q;
      discard_d     = discard_q;
      req_hold_d    = 1'b0;
      rd_ptr_d      = rd_ptr_q;
      wr_ptr_d      = wr_ptr_q;
      count_d       = count_q;
      pc_mem_d      = pc_mem_q;
      data_mem_d    = data_mem_q;
      push_s        = 1'b0;
      pop_s         = 1'b0;

      case (state_q)
         IDLE: begin
            if (fetch_en_i) begin
               state_d      = FETCH;
               fetch_addr_d = boot_addr_i;
               resp_pc_d    = boot_addr_i;
            end else begin
               state_d      = IDLE;
            end
         end
         FETCH: begin
            if (redirect_i) begin
               // Everything already requested becomes stale, including a grant and a response in this cycle.
               fetch_addr_d  = redirect_tgt_s;
               resp_pc_d     = redirect_tgt_s;
               discard_d     = discard_q + outstanding_q + INC_WIDTH'(instr_gnt_i)
                               - INC_WIDTH'(instr_rvalid_i);
               outstanding_d = '0;
               count_d       = '0;
               rd_ptr_d      = '0;
               wr_ptr_d      = '0;
            end else begin
               req_hold_d = req_s & ~instr_gnt_i;
               push_s     = instr_rvalid_i & (discard_q == '0);
               pop_s      = (count_q != '0) & instr_ready_i;

               if (req_gnt_s) begin
                  fetch_addr_d = fetch_addr_q + 32'd4;
               end else begin
                  fetch_addr_d = fetch_addr_q;
               end

               if (instr_rvalid_i && (discard_q != '0)) begin
                  discard_d = discard_q - INC_WIDTH'(1);
               end else begin
                  discard_d = discard_q;
               end

               outstanding_d = outstanding_q + INC_WIDTH'(req_gnt_s) - INC_WIDTH'(push_s);
               count_d       = count_q + CNT_W'(push_s) - CNT_W'(pop_s);

               if (push_s) begin
                  pc_mem_d[wr_ptr_q]   = resp_pc_q;
                  data_mem_d[wr_ptr_q] = instr_rdata_i;
                  wr_ptr_d             = ptr_inc(wr_ptr_q);
                  resp_pc_d            = resp_pc_q + 32'd4;
               end else begin
                  wr_ptr_d             = wr_ptr_q;
               end

               if (pop_s) begin
                  rd_ptr_d = ptr_inc(rd_ptr_q);
               end else begin
                  rd_ptr_d = rd_ptr_q;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State, counter and FIFO storage registers
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q       <= IDLE;
         fetch_addr_q  <= 32'd0;
         resp_pc_q     <= 32'd0;
         outstanding_q <= '0;
         discard_q     <= '0;
         req_hold_q    <= 1'b0;
         rd_ptr_q      <= '0;
         wr_ptr_q      <= '0;
         count_q       <= '0;
         for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
            pc_mem_q[i]   <= 32'd0;
            data_mem_q[i] <= 32'd0;
         end
      end else begin
         state_q       <= state_d;
         fetch_addr_q  <= fetch_addr_d;
         resp_pc_q     <= resp_pc_d;
         outstanding_q <= outstanding_d;
         discard_q     <= discard_d;
         req_hold_q    <= req_hold_d;
         rd_ptr_q      <= rd_ptr_d;
         wr_ptr_q      <= wr_ptr_d;
         count_q       <= count_d;
         pc_mem_q      <= pc_mem_d;
         data_mem_q    <= data_mem_d;
      end
   end

endmodule

// File: tb/tb_if_prefetch_stage.sv
// Directed bench for if_prefetch_stage: a small memory model answers grants, expected PCs
// are queued by the stimulus and checked by an independent monitor at every ID handshake.
module tb_if_prefetch_stage;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        fetch_en_i;
   logic [31:0] boot_addr_i;
   logic        redirect_i;
   logic [31:0] redirect_addr_i;
   logic        instr_req_o;
   logic [31:0] instr_addr_o;
   logic        instr_gnt_i;
   logic        instr_rvalid_i;
   logic [31:0] instr_rdata_i;
   logic        instr_valid_o;
   logic        instr_ready_i;
   logic [31:0] instr_rdata_o;
   logic [31:0] instr_pc_o;
   logic        busy_o;

   int          total = 0;
   int          bad   = 0;
   logic [31:0] exp_q  [$];
   logic [31:0] pend_q [$];
   bit          resp_en = 1'b0;

   if_prefetch_stage #(.FIFO_DEPTH(2), .INC_WIDTH(3)) dut (
      .clk_i           (clk_i),
      .rst_ni          (rst_ni),
      .fetch_en_i      (fetch_en_i),
      .boot_addr_i     (boot_addr_i),
      .redirect_i      (redirect_i),
      .redirect_addr_i (redirect_addr_i),
      .instr_req_o     (instr_req_o),
      .instr_addr_o    (instr_addr_o),
      .instr_gnt_i     (instr_gnt_i),
      .instr_rvalid_i  (instr_rvalid_i),
      .instr_rdata_i   (instr_rdata_i),
      .instr_valid_o   (instr_valid_o),
      .instr_ready_i   (instr_ready_i),
      .instr_rdata_o   (instr_rdata_o),
      .instr_pc_o      (instr_pc_o),
      .busy_o          (busy_o)
   );

   always #5 clk_i = ~clk_i;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], ~a[15:0]};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk_i);
      #1;
   endtask

   task automatic drain(input string name);
      int i;
      i = 0;
      @(negedge clk_i);
      while (busy_o && i < 30) begin
         @(negedge clk_i);
         i++;
      end
      check({name, "_drain"}, {31'd0, busy_o}, 32'd0);
      check({name, "_left"}, 32'(exp_q.size()), 32'd0);
   endtask

   // Memory: one response per accepted grant, in order, one cycle later. The stage also
   // counts a grant seen during a redirect as a response it will receive and discard.
   initial begin
      instr_rvalid_i = 1'b0;
      instr_rdata_i  = 32'd0;
      forever begin
         @(negedge clk_i);
         if (!rst_ni) begin
            pend_q.delete();
         end else begin
            if (instr_rvalid_i) void'(pend_q.pop_front());
            if (instr_gnt_i && (instr_req_o || redirect_i)) pend_q.push_back(instr_addr_o);
         end
         @(posedge clk_i);
         #2;
         if (rst_ni && resp_en && pend_q.size() > 0) begin
            instr_rvalid_i = 1'b1;
            instr_rdata_i  = mem_word(pend_q[0]);
         end else begin
            instr_rvalid_i = 1'b0;
            instr_rdata_i  = 32'd0;
         end
      end
   end

   // Monitor: every word ID accepts must be the next expected PC with its memory word.
   initial begin
      logic [31:0] e;
      forever begin
         @(negedge clk_i);
         if (rst_ni && instr_valid_o && instr_ready_i) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_pop: got pc %h expected none", instr_pc_o);
            end else begin
               e = exp_q.pop_front();
               check("pop_pc", instr_pc_o, e);
               check("pop_data", instr_rdata_o, mem_word(e));
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int lat;
      int grants;
      int waited;
      bit found;

      rst_ni          = 1'b0;
      fetch_en_i      = 1'b0;
      redirect_i      = 1'b0;
      boot_addr_i     = 32'h0000_0100;
      redirect_addr_i = 32'd0;
      instr_gnt_i     = 1'b0;
      instr_ready_i   = 1'b0;
      repeat (3) @(negedge clk_i);
      check("rst_req",   {31'd0, instr_req_o},   32'd0);
      check("rst_addr",  instr_addr_o,           32'd0);
      check("rst_valid", {31'd0, instr_valid_o}, 32'd0);
      check("rst_rdata", instr_rdata_o,          32'd0);
      check("rst_pc",    instr_pc_o,             32'd0);
      check("rst_busy",  {31'd0, busy_o},        32'd0);
      cyc();
      rst_ni = 1'b1;

      // 1: streaming from boot address
      cyc();
      instr_gnt_i = 1'b1; instr_ready_i = 1'b1; resp_en = 1'b1; fetch_en_i = 1'b1;
      exp_q.push_back(32'h100); exp_q.push_back(32'h104); exp_q.push_back(32'h108);
      @(negedge clk_i);
      check("t1_idle_no_req", {31'd0, instr_req_o}, 32'd0);
      @(posedge clk_i);
      lat = 0; found = 1'b0;
      for (int i = 0; i < 8 && !found; i++) begin
         @(posedge clk_i);
         lat++;
         @(negedge clk_i);
         if (instr_valid_o) found = 1'b1;
      end
      check("t1_latency", lat, 32'd2);
      cyc();
      cyc();
      fetch_en_i = 1'b0;
      @(negedge clk_i);
      check("t1_gate", {31'd0, instr_req_o}, 32'd0);
      drain("t1");

      // 2: ID stalled, credit limit
      cyc();
      instr_ready_i = 1'b0; fetch_en_i = 1'b1;
      exp_q.push_back(32'h10C); exp_q.push_back(32'h110); exp_q.push_back(32'h114);
      grants = 0;
      repeat (6) begin
         @(negedge clk_i);
         if (instr_req_o && instr_gnt_i) grants++;
      end
      check("t2_grants", grants, 32'd2);
      check("t2_req_stop", {31'd0, instr_req_o}, 32'd0);
      check("t2_valid", {31'd0, instr_valid_o}, 32'd1);
      cyc();
      instr_ready_i = 1'b1;
      @(negedge clk_i);
      cyc();
      instr_ready_i = 1'b0;
      @(negedge clk_i);
      check("t2_refill_req", {31'd0, instr_req_o}, 32'd1);
      check("t2_refill_addr", instr_addr_o, 32'h114);
      cyc();
      fetch_en_i = 1'b0; instr_ready_i = 1'b1;
      drain("t2");

      // 3: redirect with two responses outstanding
      cyc();
      resp_en = 1'b0; instr_ready_i = 1'b1; instr_gnt_i = 1'b1; fetch_en_i = 1'b1;
      cyc();
      cyc();
      instr_gnt_i = 1'b0; redirect_i = 1'b1; redirect_addr_i = 32'h203;
      @(negedge clk_i);
      check("t3_redirect_no_req", {31'd0, instr_req_o}, 32'd0);
      cyc();
      redirect_i = 1'b0; instr_gnt_i = 1'b1; resp_en = 1'b1;
      exp_q.push_back(32'h200);
      waited = 0;
      @(negedge clk_i);
      while (!instr_req_o && waited < 10) begin
         @(negedge clk_i);
         waited++;
      end
      check("t3_req_seen", {31'd0, instr_req_o}, 32'd1);
      check("t3_addr", instr_addr_o, 32'h200);
      check("t3_wait", waited, 32'd1);
      cyc();
      fetch_en_i = 1'b0;
      drain("t3");

      // 4: grant withheld for three cycles; request held even after fetch_en drops
      cyc();
      instr_gnt_i = 1'b0; fetch_en_i = 1'b1;
      exp_q.push_back(32'h204);
      @(negedge clk_i);
      check("t4_req0", {31'd0, instr_req_o}, 32'd1);
      check("t4_addr0", instr_addr_o, 32'h204);
      cyc();
      fetch_en_i = 1'b0;
      for (int i = 1; i < 3; i++) begin
         @(negedge clk_i);
         check("t4_req_hold", {31'd0, instr_req_o}, 32'd1);
         check("t4_addr_hold", instr_addr_o, 32'h204);
         cyc();
      end
      instr_gnt_i = 1'b1;
      @(negedge clk_i);
      check("t4_req_gnt", {31'd0, instr_req_o}, 32'd1);
      check("t4_addr_gnt", instr_addr_o, 32'h204);
      cyc();
      @(negedge clk_i);
      check("t4_req_done", {31'd0, instr_req_o}, 32'd0);
      drain("t4");

      // 5: redirect in the same cycle as a grant and a response
      cyc();
      instr_gnt_i = 1'b1; fetch_en_i = 1'b1; redirect_addr_i = 32'h300;
      @(negedge clk_i);
      check("t5_req", {31'd0, instr_req_o}, 32'd1);
      check("t5_addr", instr_addr_o, 32'h208);
      cyc();
      redirect_i = 1'b1;
      @(negedge clk_i);
      check("t5_redirect_no_req", {31'd0, instr_req_o}, 32'd0);
      cyc();
      redirect_i = 1'b0; fetch_en_i = 1'b0;
      @(negedge clk_i);
      check("t5_no_deliver", {31'd0, instr_valid_o}, 32'd0);
      repeat (3) cyc();
      fetch_en_i = 1'b1;
      exp_q.push_back(32'h300);
      @(negedge clk_i);
      check("t5_target_req", {31'd0, instr_req_o}, 32'd1);
      check("t5_target_addr", instr_addr_o, 32'h300);
      cyc();
      fetch_en_i = 1'b0;
      drain("t5");

      // 6: reset with a full FIFO
      cyc();
      boot_addr_i = 32'h400; instr_ready_i = 1'b0; fetch_en_i = 1'b1;
      repeat (3) cyc();
      @(negedge clk_i);
      check("t6_full", {31'd0, instr_valid_o}, 32'd1);
      cyc();
      rst_ni = 1'b0; fetch_en_i = 1'b0;
      @(negedge clk_i);
      check("t6_rst_req",   {31'd0, instr_req_o},   32'd0);
      check("t6_rst_valid", {31'd0, instr_valid_o}, 32'd0);
      check("t6_rst_busy",  {31'd0, busy_o},        32'd0);
      check("t6_rst_addr",  instr_addr_o,           32'd0);
      check("t6_rst_pc",    instr_pc_o,             32'd0);
      cyc();
      rst_ni = 1'b1; instr_ready_i = 1'b1;
      repeat (3) @(negedge clk_i);
      check("t6_idle_req", {31'd0, instr_req_o}, 32'd0);
      cyc();
      fetch_en_i = 1'b1;
      exp_q.push_back(32'h400);
      @(negedge clk_i);
      check("t6_idle_entry", {31'd0, instr_req_o}, 32'd0);
      cyc();
      @(negedge clk_i);
      check("t6_boot_req", {31'd0, instr_req_o}, 32'd1);
      check("t6_boot_addr", instr_addr_o, 32'h400);
      cyc();
      fetch_en_i = 1'b0;
      drain("t6");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
